// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// baud_tick_gen : fractional baud / oversample tick generator with
//                 bit-boundary reconfiguration, phase resync and BCLK output
// Revision      : 1.0
// ============================================================================
module baud_tick_gen #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OSR_W        = 5,
  parameter int DEFAULT_DIV  = 3,
  parameter int DEFAULT_FRAC = 2,
  parameter int DEFAULT_OSR  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              SYNC,
  input  logic              CFG_WE,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic [FRAC_W-1:0] CFG_FRAC,
  input  logic [OSR_W-1:0]  CFG_OSR,
  output logic              CFG_PENDING,
  output logic              OS_TICK,
  output logic              MID_TICK,
  output logic              BIT_TICK,
  output logic [OSR_W-1:0]  OS_IDX,
  output logic              BCLK
);

  localparam int                c_CNT_W    = DIV_W + 1;
  localparam logic [DIV_W-1:0]  c_DIV_MIN  = DIV_W'(2);
  localparam logic [OSR_W-1:0]  c_OSR_MIN  = OSR_W'(2);
  localparam logic [DIV_W-1:0]  c_RST_DIV  = (DEFAULT_DIV < 2) ? c_DIV_MIN : DIV_W'(DEFAULT_DIV);
  localparam logic [FRAC_W-1:0] c_RST_FRAC = FRAC_W'(DEFAULT_FRAC);
  localparam logic [OSR_W-1:0]  c_RST_OSR  = (DEFAULT_OSR < 2) ? c_OSR_MIN : OSR_W'(DEFAULT_OSR);

  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [c_CNT_W-1:0] period_q, period_d;
  logic [FRAC_W-1:0]  acc_q, acc_d;
  logic [OSR_W-1:0]   os_idx_q, os_idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [OSR_W-1:0]   osr_q, osr_d;
  logic [DIV_W-1:0]   sh_div_q, sh_div_d;
  logic [FRAC_W-1:0]  sh_frac_q, sh_frac_d;
  logic [OSR_W-1:0]   sh_osr_q, sh_osr_d;
  logic               pend_q, pend_d;
  logic               os_tick_q, os_tick_d;
  logic               mid_tick_q, mid_tick_d;
  logic               bit_tick_q, bit_tick_d;
  logic               bclk_q, bclk_d;

  logic               w_last;
  logic               w_osr_last;
  logic               w_mid_hit;
  logic               w_bit_evt;
  logic               w_apply;
  logic [FRAC_W:0]    w_sum;
  logic [DIV_W-1:0]   w_src_div;
  logic [FRAC_W-1:0]  w_src_frac;
  logic [OSR_W-1:0]   w_src_osr;
  logic [DIV_W-1:0]   w_new_div;
  logic [OSR_W-1:0]   w_new_osr;

  // ">=" keeps the counters from running away if a smaller config lands mid-interval
  assign w_last     = (cnt_q >= (period_q - c_CNT_W'(1)));
  assign w_osr_last = (os_idx_q >= (osr_q - OSR_W'(1)));
  assign w_mid_hit  = (os_idx_q == ((osr_q >> 1) - OSR_W'(1)));
  assign w_bit_evt  = EN & ~SYNC & w_last & w_osr_last;
  assign w_apply    = (SYNC | ~EN | w_bit_evt) & (pend_q | CFG_WE);
  assign w_sum      = {1'b0, acc_q} + {1'b0, frac_q};

  // A write coinciding with an apply event bypasses the shadow
  assign w_src_div  = CFG_WE ? CFG_DIV  : sh_div_q;
  assign w_src_frac = CFG_WE ? CFG_FRAC : sh_frac_q;
  assign w_src_osr  = CFG_WE ? CFG_OSR  : sh_osr_q;
  assign w_new_div  = (w_src_div < c_DIV_MIN) ? c_DIV_MIN : w_src_div;
  assign w_new_osr  = (w_src_osr < c_OSR_MIN) ? c_OSR_MIN : w_src_osr;

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    acc_d      = acc_q;
    os_idx_d   = os_idx_q;
    div_d      = div_q;
    frac_d     = frac_q;
    osr_d      = osr_q;
    sh_div_d   = sh_div_q;
    sh_frac_d  = sh_frac_q;
    sh_osr_d   = sh_osr_q;
    pend_d     = pend_q;
    bclk_d     = bclk_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;

    if (SYNC) begin
      cnt_d    = '0;
      acc_d    = '0;
      os_idx_d = '0;
      period_d = {1'b0, div_q};
    end else if (EN) begin
      if (w_last) begin
        cnt_d      = '0;
        acc_d      = w_sum[FRAC_W-1:0];
        period_d   = {1'b0, div_q} + {{DIV_W{1'b0}}, w_sum[FRAC_W]};
        os_tick_d  = 1'b1;
        mid_tick_d = w_mid_hit;
        bit_tick_d = w_osr_last;
        bclk_d     = ~bclk_q;
        os_idx_d   = w_osr_last ? '0 : os_idx_q + OSR_W'(1);
      end else begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end

    if (w_apply) begin
      div_d    = w_new_div;
      frac_d   = w_src_frac;
      osr_d    = w_new_osr;
      period_d = {1'b0, w_new_div};
      acc_d    = '0;
      pend_d   = 1'b0;
    end else if (CFG_WE) begin
      sh_div_d  = CFG_DIV;
      sh_frac_d = CFG_FRAC;
      sh_osr_d  = CFG_OSR;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      period_q   <= {1'b0, c_RST_DIV};
      acc_q      <= '0;
      os_idx_q   <= '0;
      div_q      <= c_RST_DIV;
      frac_q     <= c_RST_FRAC;
      osr_q      <= c_RST_OSR;
      sh_div_q   <= c_RST_DIV;
      sh_frac_q  <= c_RST_FRAC;
      sh_osr_q   <= c_RST_OSR;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
      bclk_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      acc_q      <= acc_d;
      os_idx_q   <= os_idx_d;
      div_q      <= div_d;
      frac_q     <= frac_d;
      osr_q      <= osr_d;
      sh_div_q   <= sh_div_d;
      sh_frac_q  <= sh_frac_d;
      sh_osr_q   <= sh_osr_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
      bclk_q     <= bclk_d;
    end
  end

  assign CFG_PENDING = pend_q;
  assign OS_TICK     = os_tick_q;
  assign MID_TICK    = mid_tick_q;
  assign BIT_TICK    = bit_tick_q;
  assign OS_IDX      = os_idx_q;
  assign BCLK        = bclk_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// tb_baud_tick_gen : directed + randomized bench for baud_tick_gen
// Revision         : 1.0
// ============================================================================
module tb_baud_tick_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR_W  = 5;
  localparam int FSCALE = 1 << FRAC_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              EN = 1'b0;
  logic              SYNC = 1'b0;
  logic              CFG_WE = 1'b0;
  logic [DIV_W-1:0]  CFG_DIV = '0;
  logic [FRAC_W-1:0] CFG_FRAC = '0;
  logic [OSR_W-1:0]  CFG_OSR = '0;
  logic              CFG_PENDING;
  logic              OS_TICK;
  logic              MID_TICK;
  logic              BIT_TICK;
  logic [OSR_W-1:0]  OS_IDX;
  logic              BCLK;

  int vectors = 0;
  int miscompares = 0;

  baud_tick_gen #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W),
    .DEFAULT_DIV(3), .DEFAULT_FRAC(2), .DEFAULT_OSR(16)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .CFG_WE(CFG_WE),
    .CFG_DIV(CFG_DIV), .CFG_FRAC(CFG_FRAC), .CFG_OSR(CFG_OSR),
    .CFG_PENDING(CFG_PENDING), .OS_TICK(OS_TICK), .MID_TICK(MID_TICK),
    .BIT_TICK(BIT_TICK), .OS_IDX(OS_IDX), .BCLK(BCLK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer bookkeeping of interval, phase and config
  typedef struct {
    int cnt; int period; int acc; int idx;
    int div; int frac; int osr;
    int sdiv; int sfrac; int sosr;
    bit pend; bit os; bit mid; bit bt; bit bclk;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_state();
    mstate_t r;
    r.cnt = 0; r.period = 3; r.acc = 0; r.idx = 0;
    r.div = 3; r.frac = 2; r.osr = 16;
    r.sdiv = 3; r.sfrac = 2; r.sosr = 16;
    r.pend = 0; r.os = 0; r.mid = 0; r.bt = 0; r.bclk = 0;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit en, input bit sy,
                                   input bit we, input int cd, input int cf, input int co);
    mstate_t r = s;
    int total;
    int nd;
    int nf;
    int no;
    bit last;
    bit bit_ev;
    r.os = 0; r.mid = 0; r.bt = 0;
    last   = (s.cnt >= s.period - 1);
    bit_ev = en && !sy && last && (s.idx >= s.osr - 1);
    if (sy) begin
      r.cnt = 0; r.acc = 0; r.idx = 0; r.period = s.div;
    end else if (en) begin
      if (last) begin
        total    = s.acc + s.frac;
        r.cnt    = 0;
        r.acc    = total % FSCALE;
        r.period = s.div + total / FSCALE;
        r.os     = 1;
        r.mid    = (s.idx == s.osr / 2 - 1);
        r.bt     = bit_ev;
        r.idx    = bit_ev ? 0 : s.idx + 1;
        r.bclk   = !s.bclk;
      end else begin
        r.cnt = s.cnt + 1;
      end
    end
    if ((sy || !en || bit_ev) && (s.pend || we)) begin
      nd = we ? cd : s.sdiv;
      nf = we ? cf : s.sfrac;
      no = we ? co : s.sosr;
      r.div = (nd < 2) ? 2 : nd;
      r.frac = nf;
      r.osr = (no < 2) ? 2 : no;
      r.period = r.div;
      r.acc = 0;
      r.pend = 0;
    end else if (we) begin
      r.sdiv = cd; r.sfrac = cf; r.sosr = co; r.pend = 1;
    end
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= reset_state();
    else     m <= step(m, EN, SYNC, CFG_WE, int'(CFG_DIV), int'(CFG_FRAC), int'(CFG_OSR));
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("os_tick",  int'(OS_TICK),     int'(m.os));
      check("mid_tick", int'(MID_TICK),    int'(m.mid));
      check("bit_tick", int'(BIT_TICK),    int'(m.bt));
      check("os_idx",   int'(OS_IDX),      m.idx);
      check("bclk",     int'(BCLK),        int'(m.bclk));
      check("pending",  int'(CFG_PENDING), int'(m.pend));
    end
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_os"},   int'(OS_TICK), 0);
    check({nm, "_mid"},  int'(MID_TICK), 0);
    check({nm, "_bit"},  int'(BIT_TICK), 0);
    check({nm, "_idx"},  int'(OS_IDX), 0);
    check({nm, "_bclk"}, int'(BCLK), 0);
    check({nm, "_pend"}, int'(CFG_PENDING), 0);
  endtask

  task automatic wait_os(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!OS_TICK && n < 200);
  endtask

  initial begin
    int n;
    int os_cnt;
    int bits;
    int ninth;
    int first_bit;
    int second_bit;
    int first_mid;
    int off_grid;
    int idx60;
    int ticks;
    int pend_bad;

    repeat (3) @(negedge CLK);
    #1;
    check_all_zero("reset");

    // Defaults 3 + 2/16, OSR 16
    RST = 1'b0;
    EN  = 1'b1;
    n = 0; os_cnt = 0; ninth = -1; first_bit = -1; second_bit = -1;
    repeat (110) begin
      cyc();
      n++;
      if (OS_TICK) begin
        os_cnt++;
        if (os_cnt == 9) ninth = n;
      end
      if (BIT_TICK) begin
        if (first_bit < 0) first_bit = n;
        else if (second_bit < 0) second_bit = n;
      end
    end
    check("def_first_bit", first_bit, 49);
    check("def_second_bit", second_bit, 99);
    check("def_ninth_os", ninth, 28);

    // DIV=4 FRAC=0 OSR=16 from a clean phase
    EN = 1'b0; SYNC = 1'b1; CFG_WE = 1'b1;
    CFG_DIV = 16'd4; CFG_FRAC = 4'd0; CFG_OSR = 5'd16;
    cyc();
    SYNC = 1'b0; CFG_WE = 1'b0;
    cyc();
    check("div4_no_pend", int'(CFG_PENDING), 0);
    EN = 1'b1;
    n = 0; os_cnt = 0; first_mid = -1; first_bit = -1; off_grid = 0; idx60 = -1;
    repeat (64) begin
      cyc();
      n++;
      if (OS_TICK) begin
        os_cnt++;
        if (n % 4 != 0) off_grid++;
      end
      if (MID_TICK && first_mid < 0) first_mid = n;
      if (BIT_TICK && first_bit < 0) first_bit = n;
      if (n == 60) idx60 = int'(OS_IDX);
    end
    check("div4_os_count", os_cnt, 16);
    check("div4_off_grid", off_grid, 0);
    check("div4_first_mid", first_mid, 32);
    check("div4_first_bit", first_bit, 64);
    check("div4_idx60", idx60, 15);

    // EN dropped mid-interval
    repeat (2) cyc();
    EN = 1'b0;
    ticks = 0;
    repeat (10) begin
      cyc();
      if (OS_TICK || MID_TICK || BIT_TICK) ticks++;
    end
    check("idle_ticks", ticks, 0);
    EN = 1'b1;
    wait_os(n);
    check("resume_gap", n, 2);

    // Deferred reconfiguration to DIV=6
    cyc();
    CFG_WE = 1'b1; CFG_DIV = 16'd6; CFG_FRAC = 4'd0; CFG_OSR = 5'd16;
    cyc();
    CFG_WE = 1'b0;
    check("pend_set", int'(CFG_PENDING), 1);
    n = 0; pend_bad = 0;
    while (!BIT_TICK && n < 200) begin
      if (!CFG_PENDING) pend_bad++;
      cyc();
      n++;
    end
    check("bit_seen", int'(BIT_TICK), 1);
    check("pend_held", pend_bad, 0);
    check("pend_clr_at_bit", int'(CFG_PENDING), 0);
    wait_os(n);
    check("div6_gap1", n, 6);
    wait_os(n);
    check("div6_gap2", n, 6);

    // Write coinciding with the BIT_TICK edge
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(OS_TICK && OS_IDX == 5'd15) && n < 300);
    repeat (5) cyc();
    CFG_WE = 1'b1; CFG_DIV = 16'd5; CFG_FRAC = 4'd0; CFG_OSR = 5'd16;
    cyc();
    CFG_WE = 1'b0;
    check("coinc_bit", int'(BIT_TICK), 1);
    check("coinc_pend", int'(CFG_PENDING), 0);
    wait_os(n);
    check("div5_gap", n, 5);

    // SYNC at OS_IDX 7
    n = 0;
    while (OS_IDX != 5'd7 && n < 300) begin
      cyc();
      n++;
    end
    check("idx7_reached", int'(OS_IDX), 7);
    SYNC = 1'b1;
    cyc();
    SYNC = 1'b0;
    check("sync_os", int'(OS_TICK), 0);
    check("sync_idx", int'(OS_IDX), 0);
    wait_os(n);
    check("sync_gap", n, 5);

    // Asynchronous reset mid-interval
    repeat (3) cyc();
    #2 RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    cyc();
    RST = 1'b0;

    // Clamped config: DIV 0 -> 2, OSR 1 -> 2
    SYNC = 1'b1; CFG_WE = 1'b1;
    CFG_DIV = 16'd0; CFG_FRAC = 4'd0; CFG_OSR = 5'd1;
    cyc();
    SYNC = 1'b0; CFG_WE = 1'b0;
    n = 0; os_cnt = 0; bits = 0; first_bit = -1;
    repeat (16) begin
      cyc();
      n++;
      if (OS_TICK) os_cnt++;
      if (BIT_TICK) begin
        bits++;
        if (first_bit < 0) first_bit = n;
      end
    end
    check("clamp_os_count", os_cnt, 8);
    check("clamp_bit_count", bits, 4);
    check("clamp_first_bit", first_bit, 4);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      EN       = ($urandom_range(0, 9) != 0);
      SYNC     = ($urandom_range(0, 49) == 0);
      CFG_WE   = ($urandom_range(0, 29) == 0);
      CFG_DIV  = DIV_W'($urandom_range(0, 7));
      CFG_FRAC = FRAC_W'($urandom_range(0, FSCALE - 1));
      CFG_OSR  = OSR_W'($urandom_range(0, 9));
      cyc();
    end
    EN = 1'b0; SYNC = 1'b0; CFG_WE = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
